// File: rtl/bram_fifo_ctrl_s9.sv
// bram_fifo_ctrl_s9: FWFT FIFO controller driving both ports of a 2048x9 dual-port BRAM.
// Define BRAM_FIFO_ERR_FLAGS_EN to add sticky overflow/underflow outputs.
module bram_fifo_ctrl_s9 #(
    parameter int ADDR_W       = 11,
    parameter int AFULL_THRESH = 2040
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wr_en,
    input  logic [8:0]        wr_data,
    output logic              full,
    output logic              almost_full,
    input  logic              rd_en,
    output logic [8:0]        rd_data,
    output logic              empty,
    output logic [ADDR_W:0]   count,
`ifdef BRAM_FIFO_ERR_FLAGS_EN
    output logic              overflow,
    output logic              underflow,
`endif
    output logic              ram_ena,
    output logic              ram_wea,
    output logic [ADDR_W-1:0] ram_addra,
    output logic [7:0]        ram_dia,
    output logic              ram_dipa,
    output logic              ram_enb,
    output logic [ADDR_W-1:0] ram_addrb,
    input  logic [7:0]        ram_dob,
    input  logic              ram_dopb
);
    localparam logic [ADDR_W:0] DEPTH = {1'b1, {ADDR_W{1'b0}}};
    localparam logic [ADDR_W:0] AFULL = (ADDR_W + 1)'(AFULL_THRESH);
    localparam logic [ADDR_W:0] ONE   = {{ADDR_W{1'b0}}, 1'b1};

    logic [ADDR_W:0] wr_ptr;
    logic [ADDR_W:0] rd_ptr;
    logic [ADDR_W:0] count_nxt;
    logic            ram_vld;
    logic            out_vld;
    logic            push;
    logic            pop;
    logic            issue;
    logic            load;

    // Pointers are registered, so port B can never target the address port A writes this cycle.
    always_comb begin
        push      = wr_en && !full && rst_n;
        pop       = rd_en && out_vld;
        issue     = (wr_ptr != rd_ptr) && !(ram_vld && out_vld && !pop);
        load      = ram_vld && (!out_vld || pop);
        count_nxt = (push && !pop) ? count + ONE : (pop && !push) ? count - ONE : count;
    end

    assign empty     = !out_vld;
    assign ram_ena   = push;
    assign ram_wea   = push;
    assign ram_addra = wr_ptr[ADDR_W-1:0];
    assign ram_dia   = wr_data[7:0];
    assign ram_dipa  = wr_data[8];
    assign ram_enb   = issue;
    assign ram_addrb = rd_ptr[ADDR_W-1:0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count       <= '0;
            full        <= 1'b0;
            almost_full <= 1'b0;
            ram_vld     <= 1'b0;
            out_vld     <= 1'b0;
            rd_data     <= '0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + ONE;
            if (issue)
                rd_ptr <= rd_ptr + ONE;
            count       <= count_nxt;
            full        <= count_nxt == DEPTH;
            almost_full <= count_nxt >= AFULL;
            ram_vld     <= issue || (ram_vld && !load);
            out_vld     <= load || (out_vld && !pop);
            if (load)
                rd_data <= {ram_dopb, ram_dob};
        end
    end

`ifdef BRAM_FIFO_ERR_FLAGS_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            overflow  <= overflow || (wr_en && full);
            underflow <= underflow || (rd_en && !out_vld);
        end
    end
`endif
endmodule

// File: tb/tb_bram_fifo_ctrl_s9.sv
// tb_bram_fifo_ctrl_s9: scoreboard bench for bram_fifo_ctrl_s9 with a behavioural 2048x9 BRAM.
module tb_bram_fifo_ctrl_s9;
    localparam int DEPTH = 2048;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        wr_en = 1'b0;
    logic        rd_en = 1'b0;
    logic [8:0]  wr_data = '0;
    logic        full, almost_full, empty;
    logic [8:0]  rd_data;
    logic [11:0] count;
    logic        ram_ena, ram_wea, ram_dipa, ram_enb, ram_dopb;
    logic [10:0] ram_addra, ram_addrb;
    logic [7:0]  ram_dia, ram_dob;
`ifdef BRAM_FIFO_ERR_FLAGS_EN
    logic        overflow, underflow;
`endif

    int total = 0;
    int bad = 0;
    int m_count = 0;
    int m_next = 0;
    bit chk = 1'b0;
    bit acc_push = 1'b0;
    bit acc_pop = 1'b0;
    logic [8:0] sb[$];

    bram_fifo_ctrl_s9 dut (
        .clk(clk), .rst_n(rst_n),
        .wr_en(wr_en), .wr_data(wr_data), .full(full), .almost_full(almost_full),
        .rd_en(rd_en), .rd_data(rd_data), .empty(empty), .count(count),
`ifdef BRAM_FIFO_ERR_FLAGS_EN
        .overflow(overflow), .underflow(underflow),
`endif
        .ram_ena(ram_ena), .ram_wea(ram_wea), .ram_addra(ram_addra),
        .ram_dia(ram_dia), .ram_dipa(ram_dipa),
        .ram_enb(ram_enb), .ram_addrb(ram_addrb),
        .ram_dob(ram_dob), .ram_dopb(ram_dopb)
    );

    always #5 clk = ~clk;

    logic [8:0] mem [0:DEPTH-1];
    logic [8:0] dout;
    always @(posedge clk) begin
        if (ram_ena && ram_wea)
            mem[ram_addra] <= {ram_dipa, ram_dia};
        if (ram_enb)
            dout <= mem[ram_addrb];
    end
    assign ram_dob  = dout[7:0];
    assign ram_dopb = dout[8];

    // Monitor: per-cycle flag checks against the model, and scoreboard compare on each pop.
    always begin
        @(negedge clk);
        #2;
        if (chk && rst_n) begin
            total++;
            if (count !== 12'(m_count)) begin bad++; $display("FAIL count got=%0d want=%0d", count, m_count); end
            total++;
            if (full !== (m_count == DEPTH)) begin bad++; $display("FAIL full got=%b count=%0d", full, m_count); end
            total++;
            if (almost_full !== (m_count >= 2040)) begin bad++; $display("FAIL almost_full got=%b count=%0d", almost_full, m_count); end
            total++;
            if (ram_ena !== acc_push || ram_wea !== acc_push) begin bad++; $display("FAIL ram_ena got=%b/%b want=%b", ram_ena, ram_wea, acc_push); end
            if (ram_ena && ram_enb) begin
                total++;
                if (ram_addra === ram_addrb) begin bad++; $display("FAIL collision addr=%0d", ram_addra); end
            end
            if (acc_pop) begin
                total++;
                if (sb.size() == 0) begin
                    bad++;
                    $display("FAIL pop_data got=%h want=none (scoreboard empty)", rd_data);
                end else begin
                    logic [8:0] e;
                    e = sb.pop_front();
                    if (rd_data !== e) begin bad++; $display("FAIL pop_data got=%h want=%h", rd_data, e); end
                end
            end
        end
    end

    task automatic cyc(input logic w, input logic [8:0] d, input logic r);
        @(negedge clk);
        m_count = m_next;
        wr_en = w;
        wr_data = d;
        rd_en = r;
        acc_push = w && (m_count != DEPTH);
        acc_pop = r && !empty;
        if (acc_push)
            sb.push_back(d);
        m_next = m_count + int'(acc_push) - int'(acc_pop);
    endtask

    task automatic test_reset;
        repeat (2) @(negedge clk);
        total++;
        if (empty !== 1'b1 || full !== 1'b0 || almost_full !== 1'b0) begin
            bad++; $display("FAIL reset_flags got e=%b f=%b af=%b want 1/0/0", empty, full, almost_full);
        end
        total++;
        if (count !== 12'd0 || rd_data !== 9'd0) begin bad++; $display("FAIL reset_data got count=%0d rd=%h want 0/0", count, rd_data); end
        total++;
        if (ram_ena !== 1'b0 || ram_wea !== 1'b0 || ram_enb !== 1'b0) begin
            bad++; $display("FAIL reset_ram got %b%b%b want 000", ram_ena, ram_wea, ram_enb);
        end
`ifdef BRAM_FIFO_ERR_FLAGS_EN
        total++;
        if (overflow !== 1'b0 || underflow !== 1'b0) begin bad++; $display("FAIL reset_err got %b%b want 00", overflow, underflow); end
`endif
        rst_n = 1'b1;
        chk = 1'b1;
    endtask

    task automatic test_latency;
        cyc(1'b1, 9'h1A5, 1'b0);
        cyc(1'b0, 9'h0, 1'b0);
        #3 total++;
        if (empty !== 1'b1) begin bad++; $display("FAIL lat_k got empty=%b want 1", empty); end
        cyc(1'b0, 9'h0, 1'b0);
        #3 total++;
        if (empty !== 1'b1) begin bad++; $display("FAIL lat_k1 got empty=%b want 1", empty); end
        cyc(1'b0, 9'h0, 1'b0);
        #3 total++;
        if (empty !== 1'b0 || rd_data !== 9'h1A5 || count !== 12'd1) begin
            bad++; $display("FAIL lat_k2 got e=%b rd=%h cnt=%0d want 0/1a5/1", empty, rd_data, count);
        end
        cyc(1'b1, 9'h0C3, 1'b1);
        cyc(1'b0, 9'h0, 1'b0);
        #3 total++;
        if (empty !== 1'b1 || count !== 12'd1) begin bad++; $display("FAIL c1_pp got e=%b cnt=%0d want 1/1", empty, count); end
        cyc(1'b0, 9'h0, 1'b0);
        cyc(1'b0, 9'h0, 1'b0);
        #3 total++;
        if (empty !== 1'b0 || rd_data !== 9'h0C3) begin bad++; $display("FAIL c1_next got e=%b rd=%h want 0/0c3", empty, rd_data); end
        cyc(1'b0, 9'h0, 1'b1);
        cyc(1'b0, 9'h0, 1'b0);
    endtask

    task automatic test_fill_overflow;
        for (int i = 0; i < DEPTH; i++)
            cyc(1'b1, 9'(i), 1'b0);
        cyc(1'b0, 9'h0, 1'b0);
        #3 total++;
        if (full !== 1'b1 || almost_full !== 1'b1 || count !== 12'd2048) begin
            bad++; $display("FAIL fill got f=%b af=%b cnt=%0d want 1/1/2048", full, almost_full, count);
        end
        cyc(1'b1, 9'h0AA, 1'b0);
        cyc(1'b0, 9'h0, 1'b0);
        #3 total++;
        if (count !== 12'd2048) begin bad++; $display("FAIL ovf_push got cnt=%0d want 2048", count); end
`ifdef BRAM_FIFO_ERR_FLAGS_EN
        total++;
        if (overflow !== 1'b1) begin bad++; $display("FAIL overflow got=%b want 1", overflow); end
`endif
    endtask

    task automatic test_drain;
        int bubbles = 0;
        for (int i = 0; i < DEPTH; i++) begin
            cyc(1'b0, 9'h0, 1'b1);
            if (empty) bubbles++;
        end
        cyc(1'b0, 9'h0, 1'b0);
        #3 total++;
        if (bubbles != 0) begin bad++; $display("FAIL drain_gaps got=%0d want 0", bubbles); end
        total++;
        if (empty !== 1'b1 || count !== 12'd0 || sb.size() != 0) begin
            bad++; $display("FAIL drain_end got e=%b cnt=%0d left=%0d want 1/0/0", empty, count, sb.size());
        end
    endtask

    task automatic test_full_pushpop;
        for (int i = 0; i < DEPTH; i++)
            cyc(1'b1, 9'(i ^ 'h155), 1'b0);
        cyc(1'b0, 9'h0, 1'b0);
        #3 total++;
        if (full !== 1'b1) begin bad++; $display("FAIL refill got full=%b want 1", full); end
        cyc(1'b1, 9'h1FF, 1'b1);
        cyc(1'b0, 9'h0, 1'b0);
        #3 total++;
        if (count !== 12'd2047 || full !== 1'b0) begin bad++; $display("FAIL full_pp got cnt=%0d f=%b want 2047/0", count, full); end
        for (int i = 0; i < 3000 && !empty; i++)
            cyc(1'b0, 9'h0, 1'b1);
        cyc(1'b0, 9'h0, 1'b0);
        cyc(1'b0, 9'h0, 1'b0);
        #3 total++;
        if (empty !== 1'b1 || count !== 12'd0 || sb.size() != 0) begin
            bad++; $display("FAIL full_pp_drain got e=%b cnt=%0d left=%0d want 1/0/0", empty, count, sb.size());
        end
    endtask

    task automatic test_stream;
        int bubbles = 0;
        for (int i = 0; i < 5; i++)
            cyc(1'b1, 9'(i + 'h40), 1'b0);
        repeat (4) cyc(1'b0, 9'h0, 1'b0);
        #3 total++;
        if (empty !== 1'b0 || count !== 12'd5) begin bad++; $display("FAIL prime got e=%b cnt=%0d want 0/5", empty, count); end
        for (int i = 0; i < 5000; i++) begin
            cyc(1'b1, 9'($urandom), 1'b1);
            if (empty || count != 12'd5) bubbles++;
        end
        total++;
        if (bubbles != 0) begin bad++; $display("FAIL stream_bubbles got=%0d want 0", bubbles); end
        for (int i = 0; i < 20 && !empty; i++)
            cyc(1'b0, 9'h0, 1'b1);
        cyc(1'b0, 9'h0, 1'b0);
        #3 total++;
        if (empty !== 1'b1 || sb.size() != 0) begin bad++; $display("FAIL stream_end got e=%b left=%0d want 1/0", empty, sb.size()); end
    endtask

    task automatic test_mid_reset;
        for (int i = 0; i < 37; i++)
            cyc(1'b1, 9'(i + 'h100), 1'b0);
        repeat (4) cyc(1'b0, 9'h0, 1'b0);
        #3 total++;
        if (count !== 12'd37) begin bad++; $display("FAIL pre_rst got cnt=%0d want 37", count); end
        chk = 1'b0;
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1 total++;
        if (count !== 12'd0 || empty !== 1'b1 || full !== 1'b0 || rd_data !== 9'd0 || ram_enb !== 1'b0) begin
            bad++; $display("FAIL async_rst got cnt=%0d e=%b f=%b rd=%h enb=%b want 0/1/0/0/0", count, empty, full, rd_data, ram_enb);
        end
        sb.delete();
        m_count = 0;
        m_next = 0;
        acc_push = 1'b0;
        acc_pop = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        chk = 1'b1;
        cyc(1'b1, 9'h055, 1'b0);
        repeat (3) cyc(1'b0, 9'h0, 1'b0);
        #3 total++;
        if (empty !== 1'b0 || rd_data !== 9'h055) begin bad++; $display("FAIL post_rst got e=%b rd=%h want 0/055", empty, rd_data); end
        cyc(1'b0, 9'h0, 1'b1);
        cyc(1'b0, 9'h0, 1'b0);
`ifdef BRAM_FIFO_ERR_FLAGS_EN
        #3 total++;
        if (underflow !== 1'b0) begin bad++; $display("FAIL underflow_pre got=%b want 0", underflow); end
`endif
        cyc(1'b0, 9'h0, 1'b1);
        cyc(1'b0, 9'h0, 1'b0);
        #3 total++;
        if (empty !== 1'b1 || count !== 12'd0) begin bad++; $display("FAIL empty_pop got e=%b cnt=%0d want 1/0", empty, count); end
`ifdef BRAM_FIFO_ERR_FLAGS_EN
        total++;
        if (underflow !== 1'b1) begin bad++; $display("FAIL underflow got=%b want 1", underflow); end
`endif
    endtask

    initial begin
        test_reset();
        test_latency();
        test_fill_overflow();
        test_drain();
        test_full_pushpop();
        test_stream();
        test_mid_reset();
        cyc(1'b0, 9'h0, 1'b0);
        #3 chk = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
